// File: rtl/digit_uart_sequencer_pkg.sv
// Shared definitions for the digit-to-UART sequencer: state encoding, the
// ASCII line terminators and a helper for the largest DIGITS-digit value.
// Optional feature macro: DIGIT_SEQ_CRLF_EN (adds the CR and LF states).
package digit_uart_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CONV = 3'd1,
    ST_SKIP = 3'd2,
    ST_LOAD = 3'd3,
    ST_SEND = 3'd4,
`ifdef DIGIT_SEQ_CRLF_EN
    ST_CR   = 3'd5,
    ST_LF   = 3'd6,
`endif
    ST_DONE = 3'd7
  } seqState_e;

  // Tells SEND which kind of byte it is currently handing over.
  typedef enum logic [1:0] {
    BYTE_DIGIT = 2'd0,
    BYTE_CR    = 2'd1,
    BYTE_LF    = 2'd2
  } byteKind_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Largest value representable with the given number of decimal digits.
  function automatic int unsigned maxValue(input int unsigned digits);
    int unsigned p;
    p = 1;
    for (int i = 0; i < int'(digits); i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

endpackage

// File: rtl/digit_uart_sequencer_bin2bcd_iter.sv
// Iterative double-dabble binary-to-BCD engine: one shift per cycle,
// exactly VAL_W cycles after start_i. done_o is high during the final
// shift cycle; bcd_o holds the finished result from the next cycle on
// and stays stable until the next start_i.
module bin2bcd_iter #(
  parameter int VAL_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [VAL_W-1:0]      value_i,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int CNT_W = $clog2(VAL_W + 1);

  logic [VAL_W-1:0]    bin_q, bin_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, bcdAdj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                active_q, active_d;

  // Add-3 correction on every nibble that would overflow past 9 when doubled.
  always_comb begin
    bcdAdj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcdAdj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Load on start, otherwise shift the corrected BCD and binary left once.
  always_comb begin
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start_i) begin
      bin_d    = value_i;
      bcd_d    = '0;
      cnt_d    = CNT_W'(VAL_W);
      active_d = 1'b1;
    end else if (active_q) begin
      {bcd_d, bin_d} = {bcdAdj[4*DIGITS-2:0], bin_q, 1'b0};
      cnt_d          = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        active_d = 1'b0;
      end
    end
  end

  // Engine registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign done_o = active_q && (cnt_q == CNT_W'(1));
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/digit_uart_sequencer.sv
// Converts a binary value to DIGITS decimal digits and sends them MSB-first
// as ASCII bytes over a valid/ready handshake, driving an external
// digit-to-ASCII converter through dig_out/ascii_in.
// Optional feature macro: DIGIT_SEQ_CRLF_EN appends CR and LF bytes.
module digit_uart_sequencer
  import digit_uart_sequencer_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int VAL_W       = 14,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [VAL_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [3:0]       dig_out,
  input  logic [7:0]       ascii_in,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [VAL_W-1:0] MAX_VAL = VAL_W'(maxValue(DIGITS));

  seqState_e           state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [7:0]          txData_q, txData_d;
  logic                txValid_q, txValid_d;
  logic [3:0]          dig_q, dig_d;
`ifdef DIGIT_SEQ_CRLF_EN
  byteKind_e           kind_q, kind_d;
`endif

  logic                accept;
  logic [VAL_W-1:0]    satValue;
  logic                engDone;
  logic [4*DIGITS-1:0] bcdVal;
  logic [3:0]          curNibble;

  assign accept    = (state_q == ST_IDLE) && start;
  assign satValue  = (value > MAX_VAL) ? MAX_VAL : value;
  assign curNibble = bcdVal[{idx_q, 2'b00} +: 4];

  bin2bcd_iter #(
    .VAL_W  (VAL_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (accept),
    .value_i (satValue),
    .done_o  (engDone),
    .bcd_o   (bcdVal)
  );

  // State and datapath registers; reset abandons any transfer at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      txData_q  <= 8'h00;
      txValid_q <= 1'b0;
      dig_q     <= 4'h0;
`ifdef DIGIT_SEQ_CRLF_EN
      kind_q    <= BYTE_DIGIT;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      txData_q  <= txData_d;
      txValid_q <= txValid_d;
      dig_q     <= dig_d;
`ifdef DIGIT_SEQ_CRLF_EN
      kind_q    <= kind_d;
`endif
    end
  end

  // Next-state and datapath updates for the sequencing FSM.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    txData_d  = txData_q;
    txValid_d = txValid_q;
    dig_d     = dig_q;
`ifdef DIGIT_SEQ_CRLF_EN
    kind_d    = kind_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CONV;
      end
      ST_CONV: begin
        if (engDone) begin
          idx_d   = IDX_W'(DIGITS - 1);
          state_d = ST_SKIP;
        end
      end
      ST_SKIP: begin
        if ((LZ_SUPPRESS != 0) && (idx_q != '0) && (curNibble == 4'h0)) begin
          idx_d = idx_q - IDX_W'(1);
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        dig_d     = curNibble;
        txData_d  = ascii_in;
        txValid_d = 1'b1;
`ifdef DIGIT_SEQ_CRLF_EN
        kind_d    = BYTE_DIGIT;
`endif
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (txValid_q && tx_ready) begin
          txValid_d = 1'b0;
`ifdef DIGIT_SEQ_CRLF_EN
          if (kind_q == BYTE_CR) begin
            state_d = ST_LF;
          end else if (kind_q == BYTE_LF) begin
            state_d = ST_DONE;
          end else if (idx_q == '0) begin
            state_d = ST_CR;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = ST_LOAD;
          end
`else
          if (idx_q == '0) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = ST_LOAD;
          end
`endif
        end
      end
`ifdef DIGIT_SEQ_CRLF_EN
      ST_CR: begin
        txData_d  = ASCII_CR;
        txValid_d = 1'b1;
        kind_d    = BYTE_CR;
        state_d   = ST_SEND;
      end
      ST_LF: begin
        txData_d  = ASCII_LF;
        txValid_d = 1'b1;
        kind_d    = BYTE_LF;
        state_d   = ST_SEND;
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from the registered state; the digit is live in LOAD.
  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    dig_out  = (state_q == ST_LOAD) ? curNibble : dig_q;
    tx_data  = txData_q;
    tx_valid = txValid_q;
  end

endmodule

// File: tb/tb_digit_uart_sequencer.sv
// Self-checking bench for digit_uart_sequencer. Two instances run side by
// side on the same stimulus: one with leading-zero suppression, one without.
// Expected byte streams come from plain decimal arithmetic on the value.
// Honours DIGIT_SEQ_CRLF_EN (expects trailing 0D 0A when defined).
`timescale 1ns/1ps
module tb_digit_uart_sequencer;

  localparam int DIGITS   = 4;
  localparam int VAL_W    = 14;
  localparam int MAX_VAL  = 9999;
  localparam int BUDGET   = 600;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [VAL_W-1:0] value;
  logic txReady;

  logic       busyF, doneF, txValidF;
  logic [3:0] digF;
  logic [7:0] asciiF, txDataF;
  logic       busyL, doneL, txValidL;
  logic [3:0] digL;
  logic [7:0] asciiL, txDataL;

  // External digit-to-ASCII converters, one per instance.
  assign asciiF = 8'h30 + {4'h0, digF};
  assign asciiL = 8'h30 + {4'h0, digL};

  digit_uart_sequencer #(.DIGITS(DIGITS), .VAL_W(VAL_W), .LZ_SUPPRESS(0)) dutFull (
    .clk(clk), .rst_n(rst_n), .start(start), .value(value),
    .busy(busyF), .done(doneF), .dig_out(digF), .ascii_in(asciiF),
    .tx_data(txDataF), .tx_valid(txValidF), .tx_ready(txReady)
  );

  digit_uart_sequencer #(.DIGITS(DIGITS), .VAL_W(VAL_W), .LZ_SUPPRESS(1)) dutLz (
    .clk(clk), .rst_n(rst_n), .start(start), .value(value),
    .busy(busyL), .done(doneL), .dig_out(digL), .ascii_in(asciiL),
    .tx_data(txDataL), .tx_valid(txValidL), .tx_ready(txReady)
  );

  always #5 clk = ~clk;

  int totalChecks = 0;
  int passChecks  = 0;

  logic [7:0] gotF[$], gotL[$], expF[$], expL[$];
  int skipL;
  int doneCntF, doneCntL;
  logic holdF, holdL, gapF, gapL, busyPrevF, busyPrevL, donePrevF, donePrevL;
  logic [7:0] holdDataF, holdDataL;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      passChecks++;
    end
  endtask

  // Reference: decimal digits of the saturated value, MSB first.
  task automatic buildExpected(input int val);
    int sat;
    int d[DIGITS];
    int p;
    int first;
    sat = (val > MAX_VAL) ? MAX_VAL : val;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d[i] = (sat / p) % 10;
      p = p * 10;
    end
    first = DIGITS - 1;
    while (first > 0 && d[first] == 0) first--;
    expF.delete();
    expL.delete();
    for (int i = DIGITS - 1; i >= 0; i--) begin
      expF.push_back(8'(48 + d[i]));
      if (i <= first) expL.push_back(8'(48 + d[i]));
    end
    skipL = DIGITS - 1 - first;
`ifdef DIGIT_SEQ_CRLF_EN
    expF.push_back(8'h0D); expF.push_back(8'h0A);
    expL.push_back(8'h0D); expL.push_back(8'h0A);
`endif
  endtask

  // Bus monitor: records handshakes and checks hold/gap/busy rules.
  always @(negedge clk) begin
    if (!rst_n) begin
      holdF = 0; holdL = 0; gapF = 0; gapL = 0;
      busyPrevF = 0; busyPrevL = 0; donePrevF = 0; donePrevL = 0;
    end else begin
      if (holdF) begin
        checkOutput("holdValidF", txValidF, 1);
        checkOutput("holdDataF", txDataF, holdDataF);
      end
      if (holdL) begin
        checkOutput("holdValidL", txValidL, 1);
        checkOutput("holdDataL", txDataL, holdDataL);
      end
      if (gapF) checkOutput("gapF", txValidF, 0);
      if (gapL) checkOutput("gapL", txValidL, 0);
      if (busyPrevF && !busyF) checkOutput("busyAfterDoneF", donePrevF, 1);
      if (busyPrevL && !busyL) checkOutput("busyAfterDoneL", donePrevL, 1);
      gapF = txValidF && txReady;
      gapL = txValidL && txReady;
      holdF = txValidF && !txReady;
      holdL = txValidL && !txReady;
      holdDataF = txDataF;
      holdDataL = txDataL;
      if (txValidF && txReady) gotF.push_back(txDataF);
      if (txValidL && txReady) gotL.push_back(txDataL);
      if (doneF) doneCntF++;
      if (doneL) doneCntL++;
      busyPrevF = busyF; busyPrevL = busyL;
      donePrevF = doneF; donePrevL = doneL;
    end
  end

  // One transfer: readyMode 0 = always ready, 1 = random, 2 = stall byte 2
  // for five cycles. pokeAt/resetAt give the cycle for a stray start or a
  // mid-transfer reset (-1 = none). Cycle 1 is the accepting edge.
  task automatic applyStimulus(input int val, input int readyMode, input int pokeAt, input int resetAt);
    int k, firstF, firstL, stallCnt;
    bit aborted;
    buildExpected(val);
    gotF.delete(); gotL.delete();
    doneCntF = 0; doneCntL = 0;
    firstF = -1; firstL = -1; stallCnt = 0; aborted = 0;
    txReady = 1;
    start = 1;
    value = VAL_W'(val);
    @(posedge clk); #1;
    start = 0;
    k = 1;
    while (k < BUDGET && !(doneCntF > 0 && doneCntL > 0)) begin
      @(posedge clk); #1;
      k++;
      start = 0;
      if (firstF < 0 && txValidF) firstF = k;
      if (firstL < 0 && txValidL) firstL = k;
      if (k == pokeAt) begin
        checkOutput("pokeInSend", txValidF, 1);
        start = 1;
        value = VAL_W'(val ^ 16'h1555);
      end
      if (k == resetAt) begin
        checkOutput("validBeforeReset", txValidF, 1);
        rst_n = 0;
        #2;
        checkOutput("rstValidF", txValidF, 0);
        checkOutput("rstBusyF", busyF, 0);
        checkOutput("rstValidL", txValidL, 0);
        checkOutput("rstBusyL", busyL, 0);
        @(posedge clk); #1;
        rst_n = 1;
        aborted = 1;
        break;
      end
      case (readyMode)
        0: txReady = 1;
        1: txReady = ($urandom_range(0, 3) != 0);
        default: txReady = !(gotF.size() == 1 && stallCnt < 5);
      endcase
      if (readyMode == 2 && !txReady && txValidF) begin
        stallCnt++;
        checkOutput("stallData", txDataF, expF[1]);
      end
    end
    txReady = 1;
    if (aborted) begin
      @(posedge clk); #1;
      checkOutput("idleAfterReset", busyF, 0);
      return;
    end
    checkOutput("timeout", (k < BUDGET), 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("countF", gotF.size(), expF.size());
    checkOutput("countL", gotL.size(), expL.size());
    for (int i = 0; i < gotF.size() && i < expF.size(); i++) checkOutput("byteF", gotF[i], expF[i]);
    for (int i = 0; i < gotL.size() && i < expL.size(); i++) checkOutput("byteL", gotL[i], expL[i]);
    checkOutput("doneOnceF", doneCntF, 1);
    checkOutput("doneOnceL", doneCntL, 1);
    checkOutput("idleBusyF", busyF, 0);
    checkOutput("idleBusyL", busyL, 0);
    checkOutput("latencyF", firstF, VAL_W + 3);
    checkOutput("latencyL", firstL, VAL_W + 3 + skipL);
    if (readyMode == 2) checkOutput("stallCycles", stallCnt, 5);
  endtask

  initial begin
    rst_n = 0; start = 0; value = '0; txReady = 1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstBusy", busyF, 0);
    checkOutput("rstDone", doneF, 0);
    checkOutput("rstValid", txValidF, 0);
    checkOutput("rstData", txDataF, 8'h00);
    checkOutput("rstDig", digF, 4'h0);
    checkOutput("rstValidLz", txValidL, 0);
    rst_n = 1;
    @(posedge clk); #1;

    applyStimulus(1234, 0, -1, -1);
    applyStimulus(7, 0, -1, -1);
    applyStimulus(0, 0, -1, -1);
    applyStimulus(12000, 0, -1, -1);
    applyStimulus(1234, 2, -1, -1);
    applyStimulus(5678, 0, VAL_W + 3, -1);
    applyStimulus(1234, 0, -1, VAL_W + 3);
    applyStimulus(1234, 0, -1, -1);
    applyStimulus(42, 0, -1, -1);
    applyStimulus(9999, 1, -1, -1);
    for (int n = 0; n < 20; n++) begin
      applyStimulus(int'($urandom_range(0, 16383)), int'($urandom_range(0, 1)), -1, -1);
    end

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule
